// File: rtl/chan_reg_pkg.sv
// chan_reg_pkg: address map, bit positions and reset values for the channel register bank
package chan_reg_pkg;
  localparam logic [6:0] ADDR_VERSION = 7'h00;
  localparam logic [6:0] ADDR_ENABLE = 7'h01;
  localparam logic [6:0] ADDR_MODE = 7'h02;
  localparam logic [6:0] ADDR_PRESC = 7'h03;
  localparam logic [6:0] ADDR_CTRL = 7'h04;
  localparam logic [6:0] ADDR_STATUS = 7'h05;
  localparam logic [6:0] ADDR_CH_BASE = 7'h10;
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_SYNC_ARM = 2;
  localparam int ST_PENDING = 0;
  localparam int ST_BAD_ADDR = 1;
  localparam int ST_RO_WRITE = 2;
  localparam int MODE_MOD = 0;
  localparam int MODE_CLK_MOD = 4;
  localparam int RST_PRESC = 3;
  localparam int RST_COUNT = 1;
  localparam int RST_DAC = 0;
  localparam int FR_RW = 23;
  localparam int FR_ADDR_HI = 22;
  localparam int FR_ADDR_LO = 16;
  localparam int FR_DATA_HI = 15;
  localparam int FR_DATA_LO = 0;
endpackage

// File: rtl/shadow_reg.sv
// shadow_reg: one shadow/active register pair with auto-apply and atomic commit
module shadow_reg #(
  parameter int W = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         commit,
  input  logic         auto,
  output logic [W-1:0] shadow,
  output logic [W-1:0] active
);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow <= RST;
      active <= RST;
    end else begin
      shadow <= wr ? wdata : shadow;
      active <= (wr && auto) ? wdata : commit ? shadow : active;
    end
  end
endmodule

// File: rtl/chan_reg_bank.sv
// chan_reg_bank: SPI-fed double-buffered configuration registers for the delay generator
module chan_reg_bank
  import chan_reg_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CNT_W = 16,
  parameter int DAC_W = 8,
  parameter int PRESC_W = 8,
  parameter logic [15:0] VERSION = 16'h0200
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_done,
  input  logic [23:0]           i_frame,
  input  logic                  i_sync,
  output logic [15:0]           o_rdata,
  output logic                  o_rvalid,
  output logic                  o_pending,
  output logic                  o_mod,
  output logic                  o_clk_mod,
  output logic [PRESC_W-1:0]    o_presc,
  output logic [N_CH-1:0]       o_ch_enable,
  output logic [N_CH*CNT_W-1:0] o_ch_count,
  output logic [N_CH*DAC_W-1:0] o_ch_dac
);
  logic done_q, acc, wr_en, rd_en, ch_hit, fld_wr, wr_ctrl, commit_go, copy;
  logic bad_set, ro_set, w1c_bad, w1c_ro;
  logic auto_q, sync_arm_q, armed, commit_req, pending, bad_q, ro_q;
  logic mod_sh, clk_mod_sh;
  logic [6:0] addr, ch_off;
  logic [5:0] ch_k;
  logic [15:0] data, rd_val, ch_val;
  logic [N_CH-1:0] en_sh;
  logic [PRESC_W-1:0] presc_sh;
  logic [CNT_W-1:0] cnt_sh [N_CH];
  logic [DAC_W-1:0] dac_sh [N_CH];
  assign acc = i_frame_done && !done_q;
  assign addr = i_frame[FR_ADDR_HI:FR_ADDR_LO];
  assign data = i_frame[FR_DATA_HI:FR_DATA_LO];
  assign wr_en = acc && !i_frame[FR_RW];
  assign rd_en = acc && i_frame[FR_RW];
  assign ch_off = addr - ADDR_CH_BASE;
  assign ch_k = ch_off[6:1];
  assign ch_hit = addr >= ADDR_CH_BASE && int'(ch_k) < N_CH;
  assign fld_wr = wr_en && (addr == ADDR_ENABLE || addr == ADDR_MODE || addr == ADDR_PRESC || ch_hit);
  assign wr_ctrl = wr_en && addr == ADDR_CTRL;
  assign commit_go = wr_ctrl && data[CTRL_COMMIT] && pending;
  assign copy = commit_req || (armed && i_sync);
  assign bad_set = acc && !(addr <= ADDR_STATUS || ch_hit);
  assign ro_set = wr_en && addr == ADDR_VERSION;
  assign w1c_bad = wr_en && addr == ADDR_STATUS && data[ST_BAD_ADDR];
  assign w1c_ro = wr_en && addr == ADDR_STATUS && data[ST_RO_WRITE];
  assign o_pending = pending;
  always_comb begin
    ch_val = '0;
    for (int k = 0; k < N_CH; k++)
      if (int'(ch_k) == k) ch_val = ch_off[0] ? 16'(dac_sh[k]) : 16'(cnt_sh[k]);
  end
  assign rd_val = addr == ADDR_VERSION ? VERSION :
                  addr == ADDR_ENABLE ? 16'(en_sh) :
                  addr == ADDR_MODE ? 16'({clk_mod_sh, 3'd0, mod_sh}) :
                  addr == ADDR_PRESC ? 16'(presc_sh) :
                  addr == ADDR_CTRL ? 16'({sync_arm_q, auto_q, 1'b0}) :
                  addr == ADDR_STATUS ? 16'({ro_q, bad_q, pending}) :
                  ch_hit ? ch_val : '0;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      done_q <= 1'b1;
      auto_q <= 1'b1;
      sync_arm_q <= 1'b0;
      armed <= 1'b0;
      commit_req <= 1'b0;
      pending <= 1'b0;
      bad_q <= 1'b0;
      ro_q <= 1'b0;
      o_rdata <= '0;
      o_rvalid <= 1'b0;
    end else begin
      done_q <= i_frame_done;
      auto_q <= wr_ctrl ? data[CTRL_AUTO] : auto_q;
      sync_arm_q <= wr_ctrl ? data[CTRL_SYNC_ARM] : sync_arm_q;
      commit_req <= commit_go && !data[CTRL_SYNC_ARM];
      armed <= (commit_go && data[CTRL_SYNC_ARM]) || (armed && !copy);
      pending <= (fld_wr && !auto_q) || (pending && !copy);
      bad_q <= bad_set || (bad_q && !w1c_bad);
      ro_q <= ro_set || (ro_q && !w1c_ro);
      o_rdata <= rd_en ? rd_val : o_rdata;
      o_rvalid <= rd_en;
    end
  end
  shadow_reg #(.W(N_CH), .RST({N_CH{1'b1}})) u_enable (
    .i_clk, .i_rst, .wr(wr_en && addr == ADDR_ENABLE), .wdata(N_CH'(data)),
    .commit(copy), .auto(auto_q), .shadow(en_sh), .active(o_ch_enable)
  );
  shadow_reg #(.W(1), .RST(1'b0)) u_mod (
    .i_clk, .i_rst, .wr(wr_en && addr == ADDR_MODE), .wdata(data[MODE_MOD]),
    .commit(copy), .auto(auto_q), .shadow(mod_sh), .active(o_mod)
  );
  shadow_reg #(.W(1), .RST(1'b0)) u_clk_mod (
    .i_clk, .i_rst, .wr(wr_en && addr == ADDR_MODE), .wdata(data[MODE_CLK_MOD]),
    .commit(copy), .auto(auto_q), .shadow(clk_mod_sh), .active(o_clk_mod)
  );
  shadow_reg #(.W(PRESC_W), .RST(PRESC_W'(RST_PRESC))) u_presc (
    .i_clk, .i_rst, .wr(wr_en && addr == ADDR_PRESC), .wdata(PRESC_W'(data)),
    .commit(copy), .auto(auto_q), .shadow(presc_sh), .active(o_presc)
  );
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    shadow_reg #(.W(CNT_W), .RST(CNT_W'(RST_COUNT))) u_cnt (
      .i_clk, .i_rst, .wr(wr_en && ch_hit && ch_k == 6'(c) && !ch_off[0]), .wdata(CNT_W'(data)),
      .commit(copy), .auto(auto_q), .shadow(cnt_sh[c]), .active(o_ch_count[c*CNT_W +: CNT_W])
    );
    shadow_reg #(.W(DAC_W), .RST(DAC_W'(RST_DAC))) u_dac (
      .i_clk, .i_rst, .wr(wr_en && ch_hit && ch_k == 6'(c) && ch_off[0]), .wdata(DAC_W'(data)),
      .commit(copy), .auto(auto_q), .shadow(dac_sh[c]), .active(o_ch_dac[c*DAC_W +: DAC_W])
    );
  end
endmodule

// File: tb/tb_chan_reg_bank.sv
// tb_chan_reg_bank: directed-vector self-checking bench for chan_reg_bank
module tb_chan_reg_bank;
  logic i_clk, i_rst, i_frame_done, i_sync;
  logic [23:0] i_frame;
  logic [15:0] o_rdata;
  logic o_rvalid, o_pending, o_mod, o_clk_mod;
  logic [7:0] o_presc;
  logic [3:0] o_ch_enable;
  logic [63:0] o_ch_count;
  logic [31:0] o_ch_dac;
  int n_tests = 0;
  int n_fail = 0;
  chan_reg_bank dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_done(i_frame_done), .i_frame(i_frame), .i_sync(i_sync),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_pending(o_pending), .o_mod(o_mod),
    .o_clk_mod(o_clk_mod), .o_presc(o_presc), .o_ch_enable(o_ch_enable),
    .o_ch_count(o_ch_count), .o_ch_dac(o_ch_dac)
  );
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [6:0] a, input logic [15:0] d);
    @(negedge i_clk);
    i_frame = {1'b0, a, d};
    i_frame_done = 1'b1;
    @(negedge i_clk);
    i_frame_done = 1'b0;
  endtask
  task automatic rd(input logic [6:0] a, input logic [15:0] exp, input string tag);
    @(negedge i_clk);
    i_frame = {1'b1, a, 16'h0000};
    i_frame_done = 1'b1;
    @(negedge i_clk);
    chk({tag, "_vld"}, 64'(o_rvalid), 64'(1'b1));
    chk(tag, 64'(o_rdata), 64'(exp));
    i_frame_done = 1'b0;
    @(negedge i_clk);
    chk({tag, "_drop"}, 64'(o_rvalid), 64'(1'b0));
    chk({tag, "_hold"}, 64'(o_rdata), 64'(exp));
  endtask
  task automatic pulse_sync();
    @(negedge i_clk);
    i_sync = 1'b1;
    @(negedge i_clk);
    i_sync = 1'b0;
  endtask
  initial begin
    i_rst = 1'b1;
    i_frame_done = 1'b0;
    i_frame = '0;
    i_sync = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_rvalid", 64'(o_rvalid), 64'(1'b0));
    chk("rst_rdata", 64'(o_rdata), 64'(16'h0000));
    chk("rst_pending", 64'(o_pending), 64'(1'b0));
    chk("rst_enable", 64'(o_ch_enable), 64'(4'hF));
    chk("rst_count", o_ch_count, 64'h0001_0001_0001_0001);
    chk("rst_dac", 64'(o_ch_dac), 64'(32'h0));
    chk("rst_presc", 64'(o_presc), 64'(8'h03));
    chk("rst_mode", 64'({o_clk_mod, o_mod}), 64'(2'b00));
    rd(7'h00, 16'h0200, "rd_version");
    rd(7'h03, 16'h0003, "rd_presc");
    rd(7'h10, 16'h0001, "rd_count0");
    rd(7'h04, 16'h0002, "rd_ctrl_rst");
    wr(7'h12, 16'h1234);
    chk("auto_count1", 64'(o_ch_count[31:16]), 64'(16'h1234));
    chk("auto_count_all", o_ch_count, 64'h0001_0001_1234_0001);
    chk("auto_pending", 64'(o_pending), 64'(1'b0));
    wr(7'h04, 16'h0000);
    wr(7'h11, 16'h0055);
    wr(7'h17, 16'h00AA);
    chk("shadow_dac_hold", 64'(o_ch_dac), 64'(32'h0));
    chk("shadow_pending", 64'(o_pending), 64'(1'b1));
    rd(7'h11, 16'h0055, "rd_dac0_shadow");
    wr(7'h04, 16'h0001);
    chk("commit_acc_dac", 64'(o_ch_dac), 64'(32'h0));
    @(negedge i_clk);
    chk("commit_dac", 64'(o_ch_dac), 64'(32'hAA00_0055));
    chk("commit_pending", 64'(o_pending), 64'(1'b0));
    wr(7'h13, 16'h01FF);
    rd(7'h13, 16'h00FF, "rd_dac1_trunc");
    wr(7'h04, 16'h0004);
    wr(7'h03, 16'h0010);
    @(negedge i_clk);
    i_frame = {1'b0, 7'h04, 16'h0005};
    i_frame_done = 1'b1;
    i_sync = 1'b1;
    @(negedge i_clk);
    i_frame_done = 1'b0;
    i_sync = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("arm_presc_hold", 64'(o_presc), 64'(8'h03));
    chk("arm_pending", 64'(o_pending), 64'(1'b1));
    pulse_sync();
    chk("sync_presc", 64'(o_presc), 64'(8'h10));
    chk("sync_dac", 64'(o_ch_dac), 64'(32'hAA00_FF55));
    chk("sync_pending", 64'(o_pending), 64'(1'b0));
    wr(7'h00, 16'hFFFF);
    rd(7'h03, 16'h0010, "rd_presc_new");
    rd(7'h30, 16'h0000, "rd_bad_ch");
    rd(7'h05, 16'h0006, "rd_status_err");
    wr(7'h05, 16'h0002);
    rd(7'h05, 16'h0004, "rd_status_w1c");
    wr(7'h05, 16'h0004);
    rd(7'h05, 16'h0000, "rd_status_clr");
    wr(7'h04, 16'h0004);
    wr(7'h03, 16'h0020);
    wr(7'h04, 16'h0005);
    chk("rearm_pending", 64'(o_pending), 64'(1'b1));
    @(negedge i_clk);
    i_frame = {1'b1, 7'h00, 16'h0000};
    i_frame_done = 1'b1;
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("held_done_rvalid", 64'(o_rvalid), 64'(1'b0));
    end
    i_frame_done = 1'b0;
    pulse_sync();
    chk("rst2_presc", 64'(o_presc), 64'(8'h03));
    chk("rst2_pending", 64'(o_pending), 64'(1'b0));
    chk("rst2_dac", 64'(o_ch_dac), 64'(32'h0));
    chk("rst2_count", o_ch_count, 64'h0001_0001_0001_0001);
    chk("rst2_rdata", 64'(o_rdata), 64'(16'h0000));
    rd(7'h04, 16'h0002, "rd_ctrl_rst2");
    wr(7'h02, 16'h0011);
    chk("mode_bits", 64'({o_clk_mod, o_mod}), 64'(2'b11));
    wr(7'h01, 16'hFFF5);
    chk("enable_trunc", 64'(o_ch_enable), 64'(4'h5));
    rd(7'h01, 16'h0005, "rd_enable");
    rd(7'h02, 16'h0011, "rd_mode");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
